// File: rtl/spi_rx_slave_mc.sv
// rtl/spi_rx_slave_mc.sv - multi-select SPI mode-0 slave receiver with word FIFO and MISO echo
module spi_rx_slave_mc #(
  parameter int NUM_SEL     = 2,
  parameter int WORD_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1,
  localparam int CH_W       = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sck,
  input  logic               mosi,
  input  logic [NUM_SEL-1:0] ssel_n,
  output logic               miso,
  output logic               miso_oe,
  output logic [WORD_W-1:0]  rx_data,
  output logic [CH_W-1:0]    rx_chan,
  output logic               rx_first,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_end,
  output logic [CH_W-1:0]    frame_chan,
  output logic               overflow
);
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W  = CH_W + 1 + WORD_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d, ok_q, ok_d;
  logic [NUM_SEL-1:0]     ssel_sync_q [SYNC_STAGES];
  logic [NUM_SEL-1:0]     ssel_sync_d [SYNC_STAGES];
  logic [NUM_SEL-1:0]     armed_q, armed_d;
  logic                   sck_prev_q, sck_prev_d;
  state_t                 state_q, state_d;
  logic [CH_W-1:0]        chan_q, chan_d, frame_chan_q, frame_chan_d;
  logic                   first_pend_q, first_pend_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]      shift_q, shift_d, echo_q, echo_d;
  logic                   miso_q, miso_d, miso_oe_q, miso_oe_d, frame_end_q, frame_end_d;
  logic                   push_q, push_d;
  logic [ENT_W-1:0]       push_data_q, push_data_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]      count_q, count_d;

  logic               sck_s, mosi_s, sync_ok, sck_rise, sck_fall;
  logic [NUM_SEL-1:0] ssel_s, falls;
  logic [WORD_W-1:0]  shift_nxt, echo_sh;
  logic               full, pop, push_ok;
  logic [ENT_W-1:0]   head;

  always_comb begin
    sck_sync_d     = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ok_d           = {ok_q[SYNC_STAGES-2:0], 1'b1};
    ssel_sync_d[0] = ssel_n;
    for (int i = 1; i < SYNC_STAGES; i++) ssel_sync_d[i] = ssel_sync_q[i-1];
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ssel_s   = ssel_sync_q[SYNC_STAGES-1];
  // Only a select seen high after the synchroniser has flushed its reset value may trigger a frame.
  assign sync_ok  = ok_q[SYNC_STAGES-1];
  assign armed_d  = sync_ok ? ssel_s : '0;
  assign falls    = armed_q & ~ssel_s;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_comb begin
    shift_nxt = (MSB_FIRST != 0) ? {shift_q[WORD_W-2:0], mosi_s} : {mosi_s, shift_q[WORD_W-1:1]};
    echo_sh   = (MSB_FIRST != 0) ? (echo_q << bit_cnt_q) : (echo_q >> bit_cnt_q);
  end

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    first_pend_d = first_pend_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    echo_d       = echo_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    frame_end_d  = 1'b0;
    frame_chan_d = frame_chan_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    sck_prev_d   = sck_s;
    case (state_q)
      IDLE: begin
        if (|falls) begin
          state_d      = ACTIVE;
          for (int i = NUM_SEL - 1; i >= 0; i--) if (falls[i]) chan_d = CH_W'(i);
          first_pend_d = 1'b1;
          bit_cnt_d    = '0;
          shift_d      = '0;
          echo_d       = '0;
          miso_d       = 1'b0;
          miso_oe_d    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssel_s[chan_q]) begin
          state_d      = IDLE;
          frame_end_d  = 1'b1;
          frame_chan_d = chan_q;
          miso_d       = 1'b0;
          miso_oe_d    = 1'b0;
        end else if (sck_rise) begin
          shift_d = shift_nxt;
          if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
            push_d       = 1'b1;
            push_data_d  = {chan_q, first_pend_q, shift_nxt};
            first_pend_d = 1'b0;
            bit_cnt_d    = '0;
            echo_d       = shift_nxt;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sck_fall) begin
          miso_d = (MSB_FIRST != 0) ? echo_sh[WORD_W-1] : echo_sh[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a full FIFO still accepts a push when the head leaves in the same cycle.
  assign full     = (count_q == FCNT_W'(FIFO_DEPTH));
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push_q && (!full || pop);
  assign overflow = push_q && full && !pop;
  assign head     = mem_q[rd_ptr_q];
  assign {rx_chan, rx_first, rx_data} = rx_valid ? head : '0;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + FCNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - FCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= '0;
      mosi_sync_q  <= '0;
      ok_q         <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) ssel_sync_q[i] <= '1;
      armed_q      <= '0;
      sck_prev_q   <= 1'b0;
      state_q      <= IDLE;
      chan_q       <= '0;
      first_pend_q <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      echo_q       <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_chan_q <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ok_q         <= ok_d;
      ssel_sync_q  <= ssel_sync_d;
      armed_q      <= armed_d;
      sck_prev_q   <= sck_prev_d;
      state_q      <= state_d;
      chan_q       <= chan_d;
      first_pend_q <= first_pend_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      echo_q       <= echo_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      frame_end_q  <= frame_end_d;
      frame_chan_q <= frame_chan_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign frame_end  = frame_end_q;
  assign frame_chan = frame_chan_q;
endmodule

// File: tb/tb_spi_rx_slave_mc.sv
// tb/tb_spi_rx_slave_mc.sv - scoreboard bench for spi_rx_slave_mc (default parameters)
module tb_spi_rx_slave_mc;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic [1:0] ssel_n = 2'b11;
  logic       miso, miso_oe, rx_first, rx_valid, frame_end, overflow;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [0:0] rx_chan, frame_chan;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int exp_fe = 0;
  int ov_cnt = 0;
  int last_fc = 0;
  logic [9:0] sb[$];

  spi_rx_slave_mc dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel_n(ssel_n),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_chan(rx_chan),
    .rx_first(rx_first), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_end(frame_end), .frame_chan(frame_chan), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_end) begin
        fe_cnt++;
        last_fc = int'(frame_chan);
      end
      if (overflow) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
        else begin
          logic [9:0] e;
          e = sb.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e[7:0]));
          chk("rx_chan", 32'(rx_chan), 32'(e[9]));
          chk("rx_first", 32'(rx_first), 32'(e[8]));
        end
      end
    end
  end

  task automatic spi_bit(input logic b);
    mosi = b;
    tick(HALF);
    sck = 1'b1;
    tick(HALF);
    sck = 1'b0;
  endtask

  // mode 1: pulse rx_ready for the single cycle in which the word lands in the FIFO
  // mode 2: check rx_valid rises exactly four cycles after the final sck rise
  task automatic spi_word(input int ch, input logic [7:0] b, input logic [7:0] echo,
                          input bit first, input bit exp_push, input int mode);
    logic [7:0] r;
    r = '0;
    if (exp_push) sb.push_back({ch[0], first, b});
    for (int k = 7; k >= 0; k--) begin
      mosi = b[k];
      tick(HALF);
      r[k] = miso;
      sck = 1'b1;
      if (k == 0 && mode == 1) begin
        tick(3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(HALF - 4);
      end else if (k == 0 && mode == 2) begin
        tick(3);
        chk("lat_before", 32'(rx_valid), 32'd0);
        tick(1);
        chk("lat_at", 32'(rx_valid), 32'd1);
        tick(HALF - 4);
      end else begin
        tick(HALF);
      end
      sck = 1'b0;
    end
    chk("miso_echo", 32'(r), 32'(echo));
  endtask

  task automatic sel_high(input int ch, input bit expect_fe);
    tick(HALF);
    ssel_n[ch] = 1'b1;
    if (expect_fe) exp_fe++;
    tick(HALF + 2);
    chk("fe_cnt", 32'(fe_cnt), 32'(exp_fe));
    if (expect_fe) begin
      chk("frame_chan", 32'(frame_chan), 32'(ch));
      chk("fe_pulse_chan", 32'(last_fc), 32'(ch));
    end
    chk("miso_oe_idle", 32'(miso_oe), 32'd0);
  endtask

  task automatic frame6(input int ch, input logic [47:0] words, input int n);
    logic [7:0] prev, w;
    prev = '0;
    ssel_n[ch] = 1'b0;
    tick(HALF);
    chk("miso_oe_active", 32'(miso_oe), 32'd1);
    for (int i = 0; i < n; i++) begin
      w = words[47 - 8*i -: 8];
      spi_word(ch, w, prev, (i == 0), 1'b1, 0);
      prev = w;
    end
    sel_high(ch, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int ov0;
    tick(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_frame_end", 32'(frame_end), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(6);

    rx_ready = 1'b1;
    frame6(0, 48'hAA55_00AA_5500, 6);
    drain();
    frame6(1, 48'hAA55_00AA_5500, 6);
    drain();

    // partial trailing word is discarded
    ssel_n[0] = 1'b0;
    tick(HALF);
    spi_word(0, 8'h00, 8'h00, 1'b1, 1'b1, 0);
    spi_word(0, 8'h55, 8'h00, 1'b0, 1'b1, 0);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    sel_high(0, 1'b1);
    drain();

    // simultaneous falls claim the lowest index; the other stays low and is ignored
    ssel_n = 2'b00;
    tick(HALF);
    spi_word(0, 8'h3C, 8'h00, 1'b1, 1'b1, 0);
    sel_high(0, 1'b1);
    tick(20);
    chk("ignored_low_sel", 32'(fe_cnt), 32'(exp_fe));
    chk("ignored_low_oe", 32'(miso_oe), 32'd0);
    ssel_n[1] = 1'b1;
    tick(HALF);
    drain();

    // ssel_n[1] toggling mid-frame on channel 0
    ssel_n[0] = 1'b0;
    tick(HALF);
    spi_word(0, 8'h11, 8'h00, 1'b1, 1'b1, 0);
    ssel_n[1] = 1'b0;
    spi_word(0, 8'h22, 8'h11, 1'b0, 1'b1, 0);
    ssel_n[1] = 1'b1;
    spi_word(0, 8'h33, 8'h22, 1'b0, 1'b1, 0);
    sel_high(0, 1'b1);
    drain();

    // overflow: 6 words into a 4-deep FIFO with no consumer
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    ssel_n[0] = 1'b0;
    tick(HALF);
    for (int i = 0; i < 6; i++)
      spi_word(0, 8'(8'hC0 + i), (i == 0) ? 8'h00 : 8'(8'hC0 + i - 1), (i == 0), (i < 4), 0);
    sel_high(0, 1'b1);
    chk("ovf_valid", 32'(rx_valid), 32'd1);
    chk("ovf_pulses", 32'(ov_cnt - ov0), 32'd2);
    rx_ready = 1'b1;
    drain();
    tick(2);
    chk("ovf_empty", 32'(rx_valid), 32'd0);

    // full FIFO with a pop in the same cycle as the fifth push
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    ssel_n[1] = 1'b0;
    tick(HALF);
    for (int i = 0; i < 5; i++)
      spi_word(1, 8'(8'hA1 + i), (i == 0) ? 8'h00 : 8'(8'hA1 + i - 1), (i == 0), 1'b1,
               (i == 4) ? 1 : 0);
    sel_high(1, 1'b1);
    chk("fullpop_no_ovf", 32'(ov_cnt - ov0), 32'd0);
    chk("fullpop_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    drain();

    // word latency from an empty FIFO, left queued for the reset test
    rx_ready = 1'b0;
    ssel_n[1] = 1'b0;
    tick(HALF);
    spi_word(1, 8'h5A, 8'h00, 1'b1, 1'b1, 2);
    sel_high(1, 1'b1);

    // reset in the middle of bit 3 with ssel_n[0] held low
    ssel_n[0] = 1'b0;
    tick(HALF);
    spi_bit(1'b1);
    spi_bit(1'b0);
    mosi = 1'b1;
    tick(HALF);
    sck = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("mrst_miso_oe", 32'(miso_oe), 32'd0);
    chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mrst_rx_data", 32'(rx_data), 32'd0);
    chk("mrst_rx_chan", 32'(rx_chan), 32'd0);
    chk("mrst_rx_first", 32'(rx_first), 32'd0);
    chk("mrst_frame_chan", 32'(frame_chan), 32'd0);
    chk("mrst_miso", 32'(miso), 32'd0);
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(HALF);
    sck = 1'b0;
    tick(HALF);
    for (int i = 0; i < 16; i++) spi_bit(i[0]);
    chk("post_rst_no_push", 32'(rx_valid), 32'd0);
    chk("post_rst_no_oe", 32'(miso_oe), 32'd0);
    sel_high(0, 1'b0);
    rx_ready = 1'b1;
    frame6(0, {8'hC3, 40'h0}, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
